// File: rtl/wb_intercon_rr_pkg.sv
// Shared definitions for the round-robin Wishbone interconnect:
// bus ownership states and an index-width helper.
package wb_intercon_rr_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } bus_state_e;

    // Bits needed to hold an index in 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_intercon_rr_arbiter.sv
// Round-robin request picker: the first requester strictly above the last
// owner wins, otherwise the scan wraps to the lowest requester.
module wb_rr_arbiter
    import wb_intercon_rr_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid_o && req_i[k] && (IW'(k) > last_i)) begin
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
                valid_o  = 1'b1;
            end
        end
        // Wrap-around pass: nobody above the last owner was requesting.
        for (int k = 0; k < N; k++) begin
            if (!valid_o && req_i[k] && (IW'(k) <= last_i)) begin
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_intercon_rr.sv
// Shared-bus Wishbone interconnect: N_M masters arbitrated round-robin onto
// N_S slaves selected by base/mask decode, with unmapped and timeout errors.
module wb_intercon_rr
    import wb_intercon_rr_pkg::*;
#(
    parameter int                   N_M     = 4,
    parameter int                   N_S     = 4,
    parameter int                   ADR_W   = 32,
    parameter int                   DAT_W   = 32,
    parameter logic [N_S*ADR_W-1:0] S_BASE  = {N_S{32'h0}},
    parameter logic [N_S*ADR_W-1:0] S_MASK  = {N_S{32'hC0000000}},
    parameter int                   TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_M*ADR_W-1:0]       m_adr_i,
    input  logic [N_M*DAT_W-1:0]       m_dat_i,
    input  logic [N_M*(DAT_W/8)-1:0]   m_sel_i,
    input  logic [N_M-1:0]             m_we_i,
    input  logic [N_M-1:0]             m_cyc_i,
    input  logic [N_M-1:0]             m_stb_i,
    output logic [DAT_W-1:0]           m_dat_o,
    output logic [N_M-1:0]             m_ack_o,
    output logic [N_M-1:0]             m_err_o,
    output logic [ADR_W-1:0]           s_adr_o,
    output logic [DAT_W-1:0]           s_dat_o,
    output logic [DAT_W/8-1:0]         s_sel_o,
    output logic                       s_we_o,
    output logic [N_S-1:0]             s_cyc_o,
    output logic [N_S-1:0]             s_stb_o,
    input  logic [N_S*DAT_W-1:0]       s_dat_i,
    input  logic [N_S-1:0]             s_ack_i,
    output logic [N_M-1:0]             gnt_o
);

    localparam int SEL_W = DAT_W / 8;
    localparam int IW    = clog2_min1(N_M);
    localparam int TW    = clog2_min1(TIMEOUT + 1);
    localparam bit T_EN  = (TIMEOUT != 0);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    bus_state_e     state_q, state_d;
    logic [N_M-1:0] gnt_q, gnt_d;
    logic [IW-1:0]  gidx_q, gidx_d;
    logic [IW-1:0]  last_q, last_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           uerr_q, uerr_d;
    logic           useen_q, useen_d;

    logic [N_M-1:0] arb_gnt;
    logic [IW-1:0]  arb_idx;
    logic           arb_valid;

    logic             own, cyc_g, stb_g, acc;
    logic [ADR_W-1:0] bus_adr;
    logic [DAT_W-1:0] bus_dat;
    logic [SEL_W-1:0] bus_sel;
    logic             bus_we;
    logic [N_S-1:0]   hit_sel;
    logic             any_hit;
    logic [DAT_W-1:0] rd_dat;
    logic             ack_raw, ack_ok, tmo_fire;

    wb_rr_arbiter #(
        .N  (N_M),
        .IW (IW)
    ) u_arb (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign own   = (state_q == ST_OWN);
    assign cyc_g = |(m_cyc_i & gnt_q);
    assign stb_g = |(m_stb_i & gnt_q);
    assign acc   = own & cyc_g & stb_g;

    // One-hot AND-OR mux of the granted master; all zero while no grant.
    always_comb begin
        bus_adr = '0;
        bus_dat = '0;
        bus_sel = '0;
        bus_we  = 1'b0;
        for (int k = 0; k < N_M; k++) begin
            bus_adr = bus_adr | (m_adr_i[k*ADR_W +: ADR_W] & {ADR_W{gnt_q[k]}});
            bus_dat = bus_dat | (m_dat_i[k*DAT_W +: DAT_W] & {DAT_W{gnt_q[k]}});
            bus_sel = bus_sel | (m_sel_i[k*SEL_W +: SEL_W] & {SEL_W{gnt_q[k]}});
            bus_we  = bus_we  | (m_we_i[k] & gnt_q[k]);
        end
    end

    // Lowest-index hit wins when address windows overlap.
    always_comb begin
        hit_sel = '0;
        any_hit = 1'b0;
        for (int i = 0; i < N_S; i++) begin
            if (!any_hit &&
                ((bus_adr & S_MASK[i*ADR_W +: ADR_W]) == S_BASE[i*ADR_W +: ADR_W])) begin
                hit_sel[i] = 1'b1;
                any_hit    = 1'b1;
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < N_S; i++) begin
            rd_dat = rd_dat | (s_dat_i[i*DAT_W +: DAT_W] & {DAT_W{hit_sel[i]}});
        end
    end

    assign ack_raw  = |(s_ack_i & hit_sel);
    assign tmo_fire = T_EN && acc && any_hit && (tcnt_q == T_LAST);
    // A slave ack landing on the timeout cycle is dropped; the error wins.
    assign ack_ok   = acc & any_hit & ack_raw & ~tmo_fire;

    assign s_adr_o = bus_adr;
    assign s_dat_o = bus_dat;
    assign s_sel_o = bus_sel;
    assign s_we_o  = bus_we;
    assign s_cyc_o = {N_S{own & cyc_g}} & hit_sel;
    assign s_stb_o = {N_S{acc & ~tmo_fire}} & hit_sel;
    assign m_dat_o = own ? rd_dat : '0;
    assign m_ack_o = {N_M{ack_ok}} & gnt_q;
    assign m_err_o = {N_M{uerr_q | tmo_fire}} & gnt_q;
    assign gnt_o   = gnt_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_OWN;
                    gnt_d   = arb_gnt;
                    gidx_d  = arb_idx;
                end
            end
            ST_OWN: begin
                if (!cyc_g) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    last_d  = gidx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Stall counter only runs on mapped strobes; unmapped ones get their own error.
    always_comb begin
        tcnt_d = '0;
        if (T_EN && acc && any_hit && !ack_raw && !tmo_fire) begin
            tcnt_d = tcnt_q + TW'(1);
        end
        useen_d = acc & ~any_hit;
        uerr_d  = acc & ~any_hit & ~useen_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(N_M - 1);
            tcnt_q  <= '0;
            uerr_q  <= 1'b0;
            useen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
            uerr_q  <= uerr_d;
            useen_q <= useen_d;
        end
    end

endmodule

// File: tb/tb_wb_intercon_rr.sv
// Bench for wb_intercon_rr: directed arbitration/error scenarios followed by
// random multi-master rounds scored against a transaction-level model.
module tb_wb_intercon_rr;

    localparam int N_M = 4;
    localparam int N_S = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;

    logic clk = 1'b0;
    logic rst;
    logic [N_M*AW-1:0] m_adr_i;
    logic [N_M*DW-1:0] m_dat_i;
    logic [N_M*SW-1:0] m_sel_i;
    logic [N_M-1:0]    m_we_i, m_cyc_i, m_stb_i;
    logic [DW-1:0]     m_dat_o;
    logic [N_M-1:0]    m_ack_o, m_err_o, gnt_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o;
    logic [N_S-1:0]    s_cyc_o, s_stb_o;
    logic [N_S*DW-1:0] s_dat_i;
    logic [N_S-1:0]    s_ack_i;

    wb_intercon_rr #(
        .N_M     (N_M),
        .N_S     (N_S),
        .ADR_W   (AW),
        .DAT_W   (DW),
        .S_BASE  ({32'h40000000, 32'h30000000, 32'h20000000, 32'h00000000}),
        .S_MASK  ({4{32'hF0000000}}),
        .TIMEOUT (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .gnt_o   (gnt_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    logic [31:0] base_t [N_S] = '{32'h00000000, 32'h20000000, 32'h30000000, 32'h40000000};
    logic [31:0] mask_t [N_S] = '{32'hF0000000, 32'hF0000000, 32'hF0000000, 32'hF0000000};
    logic [31:0] slave_mem [N_S][16];
    logic [31:0] ref_mem   [N_S][16];
    logic [31:0] req_adr [N_M];
    logic [31:0] req_dat [N_M];
    logic        req_we  [N_M];
    logic [31:0] exp_q[$];
    int          rr_last;
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N_S; i++) begin
            if ((a & mask_t[i]) == base_t[i]) return i;
        end
        return N_S;
    endfunction

    // Round-robin rule: scan from last+1 upward with wrap.
    function automatic int next_rr(input logic [N_M-1:0] pend);
        for (int off = 1; off <= N_M; off++) begin
            if (pend[(rr_last + off) % N_M]) return (rr_last + off) % N_M;
        end
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic reset_dut(input bit do_chk);
        rst = 1'b1;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
        s_dat_i = '0; s_ack_i = '0;
        @(posedge clk);
        @(negedge clk);
        if (do_chk) begin
            check_eq("rst_gnt", 32'(gnt_o), 32'h0);
            check_eq("rst_ack", 32'(m_ack_o), 32'h0);
            check_eq("rst_err", 32'(m_err_o), 32'h0);
            check_eq("rst_scyc", 32'(s_cyc_o), 32'h0);
            check_eq("rst_sstb", 32'(s_stb_o), 32'h0);
            check_eq("rst_sadr", s_adr_o, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        rr_last = N_M - 1;
    endtask

    task automatic raise(input int k, input logic [31:0] a, input logic we, input logic [31:0] d);
        m_adr_i[k*AW +: AW] = a;
        m_dat_i[k*DW +: DW] = d;
        m_sel_i[k*SW +: SW] = 4'hF;
        m_we_i[k]  = we;
        m_cyc_i[k] = 1'b1;
        m_stb_i[k] = 1'b1;
        req_adr[k] = a;
        req_dat[k] = d;
        req_we[k]  = we;
    endtask

    task automatic drop(input int k);
        m_cyc_i[k] = 1'b0;
        m_stb_i[k] = 1'b0;
    endtask

    task automatic rand_access(input int k);
        int s;
        logic [31:0] a;
        s = $urandom_range(0, N_S);
        a = (s == N_S) ? 32'hF0000000 : base_t[s];
        a = a | (32'($urandom_range(0, 15)) << 2);
        raise(k, a, 1'($urandom_range(0, 1)), $urandom);
    endtask

    // Waits for the grant, plays the addressed slave, checks routing and
    // termination, then checks the release and the mandatory idle cycle.
    task automatic serve_tenure(input int owner, input int lat_req, output int wait_n);
        int slv, lat;
        logic [31:0] a;
        wait_n = 0;
        @(negedge clk);
        while (gnt_o == '0 && wait_n < 50) begin
            wait_n++;
            @(negedge clk);
        end
        a = req_adr[owner];
        slv = decode(a);
        s_dat_i = {$urandom, $urandom, $urandom, $urandom};
        check_eq("gnt", 32'(gnt_o), 32'(1) << owner);
        check_eq("s_adr", s_adr_o, a);
        check_eq("s_we", 32'(s_we_o), 32'(req_we[owner]));
        if (slv < N_S) begin
            check_eq("s_stb", 32'(s_stb_o), 32'(1) << slv);
            check_eq("s_cyc", 32'(s_cyc_o), 32'(1) << slv);
            lat = (lat_req < 0) ? $urandom_range(0, 3) : lat_req;
            for (int i = 0; i < lat; i++) begin
                check_eq("ack_early", 32'(m_ack_o), 32'h0);
                @(negedge clk);
            end
            if (!req_we[owner]) exp_q.push_back(ref_mem[slv][a[5:2]]);
            s_dat_i[slv*DW +: DW] = slave_mem[slv][s_adr_o[5:2]];
            s_ack_i[slv] = 1'b1;
            #1;
            check_eq("ack", 32'(m_ack_o), 32'(1) << owner);
            check_eq("err_on_ack", 32'(m_err_o), 32'h0);
            if (!req_we[owner]) begin
                check_eq("rdata", m_dat_o, exp_q.pop_front());
            end else begin
                check_eq("s_dat", s_dat_o, req_dat[owner]);
                check_eq("s_sel", 32'(s_sel_o), 32'hF);
                slave_mem[slv][s_adr_o[5:2]] = s_dat_o;
                ref_mem[slv][a[5:2]] = req_dat[owner];
            end
            @(posedge clk);
            #1 s_ack_i = '0;
            drop(owner);
        end else begin
            check_eq("unm_stb", 32'(s_stb_o), 32'h0);
            check_eq("unm_err_early", 32'(m_err_o), 32'h0);
            check_eq("unm_dat", m_dat_o, 32'h0);
            @(negedge clk);
            check_eq("unm_err", 32'(m_err_o), 32'(1) << owner);
            check_eq("unm_ack", 32'(m_ack_o), 32'h0);
            @(posedge clk);
            #1 drop(owner);
        end
        @(negedge clk);
        check_eq("rel_scyc", 32'(s_cyc_o), 32'h0);
        check_eq("rel_err", 32'(m_err_o), 32'h0);
        @(negedge clk);
        check_eq("idle_gap", 32'(gnt_o), 32'h0);
        rr_last = owner;
    endtask

    task automatic timeout_test();
        int n;
        @(posedge clk);
        #1 raise(0, 32'h30000010, 1'b0, 32'h0);
        n = 0;
        @(negedge clk);
        while (gnt_o == '0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_eq("to_gnt", 32'(gnt_o), 32'h1);
        for (int c = 1; c < 8; c++) begin
            check_eq("to_stall_err", 32'(m_err_o), 32'h0);
            check_eq("to_stall_stb", 32'(s_stb_o), 32'h4);
            @(negedge clk);
        end
        s_ack_i[2] = 1'b1;
        #1;
        check_eq("to_err", 32'(m_err_o), 32'h1);
        check_eq("to_stb_low", 32'(s_stb_o), 32'h0);
        check_eq("to_late_ack", 32'(m_ack_o), 32'h0);
        @(posedge clk);
        #1 s_ack_i = '0;
        drop(0);
        @(negedge clk);
        check_eq("to_err_once", 32'(m_err_o), 32'h0);
        @(negedge clk);
        check_eq("to_idle", 32'(gnt_o), 32'h0);
        rr_last = 0;
    endtask

    task automatic reset_mid_write();
        int n;
        reset_dut(1'b0);
        @(posedge clk);
        #1 raise(2, 32'h00000020, 1'b1, 32'h12345678);
        n = 0;
        @(negedge clk);
        while (gnt_o == '0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_eq("rw_gnt", 32'(gnt_o), 32'h4);
        check_eq("rw_stb", 32'(s_stb_o), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 s_ack_i[0] = 1'b1;
        @(negedge clk);
        check_eq("rw_gnt_clr", 32'(gnt_o), 32'h0);
        check_eq("rw_scyc", 32'(s_cyc_o), 32'h0);
        check_eq("rw_sstb", 32'(s_stb_o), 32'h0);
        check_eq("rw_ack", 32'(m_ack_o), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        s_ack_i = '0;
        drop(2);
        rr_last = N_M - 1;
        @(posedge clk);
        #1 raise(1, 32'h40000008, 1'b0, 32'h0);
        serve_tenure(1, -1, n);
        check_eq("rw_regrant_lat", 32'(n), 32'd1);
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        int n;
        logic [N_M-1:0] pend;
        bit first;
        for (int s = 0; s < N_S; s++) begin
            for (int w = 0; w < 16; w++) begin
                slave_mem[s][w] = 32'hA5000000 | (32'(s) << 8) | 32'(w);
                ref_mem[s][w]   = 32'hA5000000 | (32'(s) << 8) | 32'(w);
            end
        end
        reset_dut(1'b1);

        // Contention straight out of reset: pointer starts at N_M-1.
        @(posedge clk);
        #1 rand_access(0);
        rand_access(1);
        serve_tenure(0, -1, n);
        check_eq("cont_lat", 32'(n), 32'd1);
        rand_access(0);
        serve_tenure(1, -1, n);
        check_eq("cont_gap1", 32'(n), 32'd0);
        serve_tenure(0, -1, n);
        check_eq("cont_gap2", 32'(n), 32'd0);

        // Single master read from slave 1 with a two-cycle ack.
        slave_mem[1][1] = 32'hDEADBEEF;
        ref_mem[1][1]   = 32'hDEADBEEF;
        @(posedge clk);
        #1 raise(0, 32'h20000004, 1'b0, 32'h0);
        serve_tenure(0, 2, n);
        check_eq("single_lat", 32'(n), 32'd1);

        // Unmapped access.
        @(posedge clk);
        #1 raise(3, 32'hF0000000, 1'b0, 32'h0);
        serve_tenure(3, -1, n);

        // Fairness with all masters requesting continuously.
        reset_dut(1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < N_M; k++) rand_access(k);
        for (int t = 0; t < 12; t++) begin
            serve_tenure(t % N_M, -1, n);
            if (t > 0) check_eq("rr_gap", 32'(n), 32'd0);
            if (t < 8) rand_access(t % N_M);
        end

        reset_dut(1'b0);
        timeout_test();
        reset_mid_write();

        // Random rounds of simultaneous requesters.
        for (int r = 0; r < 30; r++) begin
            @(posedge clk);
            #1 pend = N_M'($urandom_range(1, (1 << N_M) - 1));
            for (int k = 0; k < N_M; k++) begin
                if (pend[k]) rand_access(k);
            end
            first = 1'b1;
            while (pend != '0) begin
                int o;
                o = next_rr(pend);
                serve_tenure(o, -1, n);
                check_eq(first ? "rnd_lat" : "rnd_gap", 32'(n), first ? 32'd1 : 32'd0);
                pend[o] = 1'b0;
                first = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_intercon_rr.md
Name: wb_intercon_rr

Overview:
- Parametrised Wishbone shared-bus interconnect: N masters, M slaves, 32-bit data.
- Next generation of the fixed 7-master/4-slave priority bus used in the SoC top level.
- Adds round-robin arbitration, a per-slave base/mask address map, error response on unmapped addresses, and a bus-timeout error.
- Sits between lm32 I/D ports (plus future DMA masters) and bram/uart/timer/gpio slaves.

Parameters:
- N_M, 4, number of masters (1..8)
- N_S, 4, number of slaves (1..8)
- ADR_W, 32, address width
- DAT_W, 32, data width; SEL width = DAT_W/8
- S_BASE, {N_S{32'h0}}, concatenated slave base addresses; slave i = S_BASE[i*ADR_W +: ADR_W]
- S_MASK, {N_S{32'hC0000000}}, concatenated decode masks; slave i hit when (adr & mask_i) == base_i
- TIMEOUT, 255, cycles a strobed access may wait for ack; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m_adr_i  in  N_M*ADR_W  master addresses, master k at [k*ADR_W +: ADR_W]
- m_dat_i  in  N_M*DAT_W  master write data
- m_sel_i  in  N_M*DAT_W/8  byte selects
- m_we_i / m_cyc_i / m_stb_i  in  N_M each  per-master control
- m_dat_o  out  DAT_W  read data, common to all masters
- m_ack_o / m_err_o  out  N_M each  per-master termination
- s_adr_o  out  ADR_W  shared slave address
- s_dat_o  out  DAT_W  shared slave write data
- s_sel_o  out  DAT_W/8  shared byte selects
- s_we_o  out  1  shared write enable
- s_cyc_o / s_stb_o  out  N_S each  per-slave cycle/strobe
- s_dat_i  in  N_S*DAT_W  slave read data
- s_ack_i  in  N_S  slave acks
- gnt_o  out  N_M  one-hot current grant (debug/status)

Behaviour:
- Reset (rst high at a clk edge): gnt = 0, last-grant pointer = N_M-1, timeout counter = 0.
  - All m_ack_o, m_err_o, s_cyc_o, s_stb_o are 0.
  - Shared s_* buses are don't-care but driven to 0 while no grant.
- FSM states:
  - IDLE: gnt = 0. If any m_cyc_i, register a grant to the first requesting master scanning from (last+1) mod N_M upward with wrap. Go to OWN. Latency: 1 cycle from cyc to slave visibility.
  - OWN: granted master's adr/dat/sel/we are muxed combinationally to s_*. Grant is held while that master's m_cyc_i = 1.
  - OWN -> IDLE: on the cycle m_cyc_i drops. gnt clears at the next edge; last <= granted index. s_cyc_o drops combinationally in the same cycle cyc drops.
  - Back-to-back: no direct OWN -> OWN handoff. There is always one IDLE cycle between owners.
- Decode (combinational in OWN):
  - hit_i = ((s_adr_o & mask_i) == base_i). Lowest-index hit wins if maps overlap.
  - s_cyc_o[i] = cyc & hit_sel_i; s_stb_o[i] = stb & hit_sel_i.
- Read data: m_dat_o = s_dat_i of the selected slave, else 0.
- Ack routing: m_ack_o[g] = s_ack_i[selected] & stb & ~timeout_fire. Non-granted masters never see ack or err.
- Unmapped access: no slave hit while stb = 1 -> m_err_o[g] = 1 for one cycle, registered (1 cycle after stb). No slave is strobed. The master must drop stb or issue a new access.
- Timeout counter:
  - Increments each cycle granted stb = 1 with no ack.
  - Clears on ack, err, or stb low.
  - When the count reaches TIMEOUT: m_err_o[g] pulses one cycle, s_stb_o is forced 0 that cycle, counter clears.
  - A slave ack arriving in the same cycle as timeout_fire is discarded; err wins.
- Simultaneous requests in IDLE: round-robin pointer decides; no master is starved for more than N_M-1 tenures.
- rst asserted mid-transfer: grant is dropped at that edge. Any slave ack in the following cycles is ignored.

Decomposition:
- Package/header wb_intercon_defs: state encoding (IDLE/OWN), CLOG2 function for index widths.
- One sub-module: wb_rr_arbiter (N-bit request vector, last pointer -> one-hot grant + index). Address decode and muxing stay in the top.

Test Plan:
- Single master: m0 reads 0x20000004 (S_BASE slave1 = 0x20000000, mask 0xF0000000); slave1 acks after 2 cycles with 0xDEADBEEF -> s_stb_o = 4'b0010 one cycle after cyc; m_dat_o = 0xDEADBEEF; m_ack_o = 4'b0001.
- Contention: m0 and m1 raise cyc in the same cycle after reset -> m0 granted first (pointer N_M-1). After m0 drops cyc: one IDLE cycle, then gnt_o = 4'b0010. Three rounds alternate 0,1,0.
- Round-robin fairness: all 4 masters hold cyc continuously, each tenure 1 access -> grant order 0,1,2,3,0,...
- Unmapped address 0xF0000000 with no matching base -> no s_stb_o. m_err_o[g] = 1 exactly one cycle, one cycle after stb.
- Timeout: TIMEOUT = 8, slave never acks -> m_err_o pulses at the 8th stalled cycle, with s_stb_o low that cycle. A late ack injected on that same cycle is dropped.
- Reset mid-write: assert rst during an OWN write -> next cycle gnt_o = 0, all s_cyc_o/s_stb_o = 0, all m_ack_o = 0. After rst release, a new request is granted normally.
